// File: rtl/lock_controller_pkg.sv
// lock_controller_pkg: shared state encodings, digit constants and key-index helper
package lock_controller_pkg;
  localparam int DIGIT_W = 2;
  localparam logic [DIGIT_W-1:0] BAD_DIGIT = 2'b11;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_PROGRAM = 3'd4,
    S_LOCKOUT = 3'd5
  } state_e;
  function automatic logic [DIGIT_W-1:0] onehot_idx(input logic [3:0] oh);
    return oh[3] ? 2'd3 : oh[2] ? 2'd2 : oh[1] ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/lock_controller_if.sv
// lock_controller_if: button inputs and status outputs of the combination lock
interface lock_controller_if;
  logic [3:0] keys;
  logic       set_btn;
  logic       sample_tick;
  logic       unlocked;
  logic       alarm;
  logic [2:0] state;
  logic [2:0] digit_count;
  logic [1:0] fail_count;
  modport master (output keys, set_btn,
                  input  sample_tick, unlocked, alarm, state, digit_count, fail_count);
  modport slave  (input  keys, set_btn,
                  output sample_tick, unlocked, alarm, state, digit_count, fail_count);
endinterface

// File: rtl/lock_key_event.sv
// lock_key_event: registered rising-edge detection of digit keys and the set button
module lock_key_event import lock_controller_pkg::*; (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         keys_i,
  input  logic               set_btn_i,
  output logic               press_o,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               bad_o,
  output logic               set_press_o
);
  logic [3:0] keys_q, rise;
  logic set_q, valid, press_q, bad_q, set_press_q;
  logic [DIGIT_W-1:0] digit_q;
  assign rise  = keys_i & ~keys_q;
  // a lone new key is a digit only if no other key is still being held
  assign valid = $onehot(rise) && (keys_i & keys_q) == 4'b0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      keys_q      <= '1;
      set_q       <= 1'b1;
      press_q     <= 1'b0;
      digit_q     <= '0;
      bad_q       <= 1'b0;
      set_press_q <= 1'b0;
    end else begin
      keys_q      <= keys_i;
      set_q       <= set_btn_i;
      press_q     <= |rise;
      digit_q     <= valid ? onehot_idx(rise) : BAD_DIGIT;
      bad_q       <= |rise && !valid;
      set_press_q <= set_btn_i & ~set_q;
    end
  assign press_o     = press_q;
  assign digit_o     = digit_q;
  assign bad_o       = bad_q;
  assign set_press_o = set_press_q;
endmodule

// File: rtl/lock_controller.sv
// lock_controller: combination-lock sequencer with code entry, lockout and reprogramming
module lock_controller import lock_controller_pkg::*; #(
  parameter int                        TICK_DIV       = 100000,
  parameter int                        CODE_LEN       = 4,
  parameter logic [2*CODE_LEN-1:0]     DEFAULT_CODE   = 8'b00_01_10_11,
  parameter int                        UNLOCK_CYCLES  = 50000000,
  parameter int                        ENTRY_TIMEOUT  = 100000000,
  parameter int                        MAX_FAILS      = 3,
  parameter int                        LOCKOUT_CYCLES = 300000000
) (
  input logic              clk,
  input logic              reset,
  lock_controller_if.slave bus
);
  localparam int EW = DIGIT_W * CODE_LEN;
  localparam int DW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  state_e state_q;
  logic [31:0] timer_q;
  logic [DW-1:0] div_q;
  logic [EW-1:0] entry_q, code_q, shifted;
  logic [2:0] cnt_q;
  logic [1:0] fail_q, fail_nxt;
  logic bad_q, last, press, bad, set_press, tick;
  logic [DIGIT_W-1:0] digit;
  lock_key_event u_key (
    .clk        (clk),
    .reset      (reset),
    .keys_i     (bus.keys),
    .set_btn_i  (bus.set_btn),
    .press_o    (press),
    .digit_o    (digit),
    .bad_o      (bad),
    .set_press_o(set_press)
  );
  assign shifted  = EW'({entry_q, digit});
  assign last     = {1'b0, cnt_q} + 4'd1 == 4'(CODE_LEN);
  assign fail_nxt = fail_q == 2'(MAX_FAILS) ? fail_q : fail_q + 2'd1;
  assign tick     = div_q == DW'(TICK_DIV - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) div_q <= '0;
    else div_q <= tick ? '0 : div_q + DW'(1);
  // timer free-runs; every entry into a timed state clears it
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      entry_q <= '0;
      code_q  <= DEFAULT_CODE;
      cnt_q   <= '0;
      fail_q  <= '0;
      bad_q   <= 1'b0;
    end else begin
      timer_q <= timer_q + 32'd1;
      case (state_q)
        S_IDLE:
          if (press) begin
            entry_q <= EW'(digit);
            bad_q   <= bad;
            cnt_q   <= 3'd1;
            timer_q <= '0;
            state_q <= S_ENTRY;
          end
        S_ENTRY, S_PROGRAM:
          if (state_q == S_PROGRAM && (set_press || (press && bad))) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bad_q   <= 1'b0;
          end else if (press) begin
            entry_q <= shifted;
            bad_q   <= bad_q | bad;
            cnt_q   <= cnt_q + 3'd1;
            timer_q <= '0;
            if (last && state_q == S_PROGRAM) begin
              code_q  <= shifted;
              cnt_q   <= '0;
              state_q <= S_IDLE;
            end else if (last) state_q <= S_CHECK;
          end else if (timer_q == 32'(ENTRY_TIMEOUT - 1)) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bad_q   <= 1'b0;
          end
        S_CHECK: begin
          cnt_q   <= '0;
          bad_q   <= 1'b0;
          timer_q <= '0;
          if (entry_q == code_q && !bad_q) begin
            fail_q  <= '0;
            state_q <= S_OPEN;
          end else begin
            fail_q  <= fail_nxt;
            state_q <= fail_nxt == 2'(MAX_FAILS) ? S_LOCKOUT : S_IDLE;
          end
        end
        S_OPEN:
          if (set_press) begin
            timer_q <= '0;
            state_q <= S_PROGRAM;
          end else if (timer_q == 32'(UNLOCK_CYCLES - 1)) state_q <= S_IDLE;
        S_LOCKOUT:
          if (timer_q == 32'(LOCKOUT_CYCLES - 1)) begin
            fail_q  <= '0;
            state_q <= S_IDLE;
          end
        default: state_q <= S_IDLE;
      endcase
    end
  assign bus.sample_tick = tick;
  assign bus.unlocked    = state_q == S_OPEN;
  assign bus.alarm       = state_q == S_LOCKOUT;
  assign bus.state       = state_q;
  assign bus.digit_count = cnt_q;
  assign bus.fail_count  = fail_q;
endmodule

// File: tb/tb_lock_controller.sv
// tb_lock_controller: directed scenarios with a state-transition scoreboard for lock_controller
module tb_lock_controller;
  typedef struct {int st; int fc; int dur;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  exp_t q[$];
  exp_t e;
  logic [2:0] prev_st = 3'd0;
  int since = 1;
  int gap = -1;
  lock_controller_if bus();
  lock_controller #(
    .TICK_DIV(4), .CODE_LEN(4), .DEFAULT_CODE(8'h1B), .UNLOCK_CYCLES(20),
    .ENTRY_TIMEOUT(50), .MAX_FAILS(3), .LOCKOUT_CYCLES(30)
  ) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask
  task automatic exp_tr(input int st, input int fc, input int dur);
    exp_t x;
    x.st = st; x.fc = fc; x.dur = dur;
    q.push_back(x);
  endtask
  task automatic press_mask(input logic [3:0] m, input bit chk_open);
    bus.keys = m;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (chk_open) chk("unlock_latency", int'(bus.unlocked), int'(i == 3));
    end
    bus.keys = 4'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic enter(input int d0, input int d1, input int d2, input int d3, input bit chk_open);
    press_mask(4'(1 << d0), 1'b0);
    press_mask(4'(1 << d1), 1'b0);
    press_mask(4'(1 << d2), 1'b0);
    press_mask(4'(1 << d3), chk_open);
  endtask
  task automatic set_pulse();
    bus.set_btn = 1'b1;
    repeat (3) @(negedge clk);
    bus.set_btn = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic wait_state(input int s, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (int'(bus.state) == s) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s: state %0d after %0d cycles, expected %0d", name, bus.state, budget, s);
  endtask
  // each state change must match the next queued expectation, including time spent in the old state
  always @(negedge clk) begin
    if (bus.state != prev_st) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL transition: unexpected change to state=%0d", bus.state);
      end else begin
        e = q.pop_front();
        if (!(int'(bus.state) == e.st && int'(bus.fail_count) == e.fc &&
              bus.unlocked == (e.st == 3) && bus.alarm == (e.st == 5) &&
              (e.dur < 0 || since == e.dur))) begin
          n_fail++;
          $display("FAIL transition: got state=%0d fail=%0d unl=%0d alm=%0d dur=%0d, want state=%0d fail=%0d dur=%0d",
                   bus.state, bus.fail_count, bus.unlocked, bus.alarm, since, e.st, e.fc, e.dur);
        end
      end
      prev_st = bus.state;
      since = 1;
    end else since++;
  end
  always @(negedge clk) begin
    if (!reset) gap = -1;
    else if (bus.sample_tick) begin
      if (gap != -1) chk("tick_period", gap, 4);
      gap = 1;
    end else if (gap != -1) gap++;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    bus.keys = 4'b0001;
    bus.set_btn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", int'(bus.state), 0);
    chk("rst_unlocked", int'(bus.unlocked), 0);
    chk("rst_alarm", int'(bus.alarm), 0);
    chk("rst_digits", int'(bus.digit_count), 0);
    chk("rst_fails", int'(bus.fail_count), 0);
    chk("rst_tick", int'(bus.sample_tick), 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("held_key_state", int'(bus.state), 0);
    chk("held_key_digits", int'(bus.digit_count), 0);
    bus.keys = 4'b0;
    repeat (3) @(negedge clk);
    chk("held_key_release", int'(bus.state), 0);
    // correct default code
    exp_tr(1, 0, -1); exp_tr(2, 0, -1); exp_tr(3, 0, 1); exp_tr(0, 0, 20);
    enter(0, 1, 2, 3, 1'b1);
    wait_state(0, 40, "open_expiry");
    chk("open_fails", int'(bus.fail_count), 0);
    // three wrong codes into lockout
    exp_tr(1, 0, -1); exp_tr(2, 0, -1); exp_tr(0, 1, 1);
    enter(3, 3, 3, 3, 1'b0);
    chk("fail1", int'(bus.fail_count), 1);
    exp_tr(1, 1, -1); exp_tr(2, 1, -1); exp_tr(0, 2, 1);
    enter(3, 3, 3, 3, 1'b0);
    chk("fail2", int'(bus.fail_count), 2);
    exp_tr(1, 2, -1); exp_tr(2, 2, -1); exp_tr(5, 3, 1); exp_tr(0, 0, 30);
    enter(3, 3, 3, 3, 1'b0);
    chk("lockout_state", int'(bus.state), 5);
    press_mask(4'b0001, 1'b0);
    press_mask(4'b0010, 1'b0);
    chk("lockout_alarm", int'(bus.alarm), 1);
    chk("lockout_ignores", int'(bus.state), 5);
    wait_state(0, 40, "lockout_expiry");
    chk("lockout_clear", int'(bus.fail_count), 0);
    // entry timeout
    exp_tr(1, 0, -1); exp_tr(0, 0, -1);
    press_mask(4'b0001, 1'b0);
    press_mask(4'b0010, 1'b0);
    chk("partial_digits", int'(bus.digit_count), 2);
    wait_state(0, 80, "entry_timeout");
    chk("timeout_digits", int'(bus.digit_count), 0);
    chk("timeout_fails", int'(bus.fail_count), 0);
    // simultaneous keys poison an otherwise correct code
    exp_tr(1, 0, -1); exp_tr(2, 0, -1); exp_tr(0, 1, 1);
    press_mask(4'b0001, 1'b0);
    press_mask(4'b0101, 1'b0);
    press_mask(4'b0100, 1'b0);
    press_mask(4'b1000, 1'b0);
    chk("multikey_fail", int'(bus.fail_count), 1);
    // program aborted by second set press
    exp_tr(1, 1, -1); exp_tr(2, 1, -1); exp_tr(3, 0, 1); exp_tr(4, 0, -1); exp_tr(0, 0, -1);
    enter(0, 1, 2, 3, 1'b1);
    set_pulse();
    chk("program_state", int'(bus.state), 4);
    press_mask(4'b1000, 1'b0);
    press_mask(4'b0100, 1'b0);
    set_pulse();
    chk("abort_state", int'(bus.state), 0);
    exp_tr(1, 0, -1); exp_tr(2, 0, -1); exp_tr(3, 0, 1); exp_tr(0, 0, 20);
    enter(0, 1, 2, 3, 1'b1);
    wait_state(0, 40, "abort_open_expiry");
    // reprogram to 3,2,1,0
    exp_tr(1, 0, -1); exp_tr(2, 0, -1); exp_tr(3, 0, 1); exp_tr(4, 0, -1); exp_tr(0, 0, -1);
    enter(0, 1, 2, 3, 1'b1);
    set_pulse();
    enter(3, 2, 1, 0, 1'b0);
    chk("reprog_state", int'(bus.state), 0);
    chk("reprog_code", int'(dut.code_q), 8'hE4);
    exp_tr(1, 0, -1); exp_tr(2, 0, -1); exp_tr(0, 1, 1);
    enter(0, 1, 2, 3, 1'b0);
    chk("old_code_fails", int'(bus.fail_count), 1);
    exp_tr(1, 1, -1); exp_tr(2, 1, -1); exp_tr(3, 0, 1); exp_tr(0, 0, 20);
    enter(3, 2, 1, 0, 1'b1);
    wait_state(0, 40, "new_code_expiry");
    // asynchronous reset while open restores the default code
    exp_tr(1, 0, -1); exp_tr(2, 0, -1); exp_tr(3, 0, 1); exp_tr(0, 0, -1);
    enter(3, 2, 1, 0, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_unlocked", int'(bus.unlocked), 0);
    chk("async_rst_state", int'(bus.state), 0);
    chk("async_rst_code", int'(dut.code_q), 8'h1B);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_tr(1, 0, -1); exp_tr(2, 0, -1); exp_tr(3, 0, 1); exp_tr(0, 0, 20);
    enter(0, 1, 2, 3, 1'b1);
    wait_state(0, 40, "default_after_reset");
    repeat (2) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
